// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit pipeline: datapath widths, the memory-stage
// state encoding and the write-back data-source encoding.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  // Write-back data source: 1 selects data returned by the memory stage.
  localparam logic WB_SEL_MEM = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter for the memory access. It counts ACCESS cycles that
// pass without an acknowledge and flags when the limit has been reached.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] count;

  // Count enabled cycles, holding at the limit; clear has priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/pipeline_mem_stage.sv
// Memory stage of the 8-bit pipeline. Non-memory ops pass through the MEM/WB
// register in one cycle; loads and stores are latched, issued on the dmem
// req/ack port and retired when the ack arrives (or abandoned on timeout),
// stalling upstream meanwhile.
//
// Handshake: dmem_req is high for every ACCESS cycle with addr/we/wdata held
// stable; the memory answers with a single-cycle dmem_ack (rdata valid with
// it). The access completes on the edge that samples dmem_ack high; an ack
// seen outside ACCESS is ignored.
module pipeline_mem_stage
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [1:0]        ra_in,
  input  logic [ADDR_W-1:0] ea_in,
  input  logic              mem_wr_en_in,
  input  logic              mem_imm_sel_in,
  input  logic              wb_wb_sel_in,
  input  logic              wb_data_sel_in,
  input  logic              wb_reg_en_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [1:0]        ra_out,
  output logic              wb_wb_sel_out,
  output logic              wb_data_sel_out,
  output logic              wb_reg_en_out,
  output logic              mem_err,
  output mem_state_t        mem_state
);

  mem_state_t        state;
  logic              mem_op;
  logic              expired;
  logic              timer_en;
  logic              timer_clr;

  // Operation captured when entering ACCESS.
  logic [DATA_W-1:0] lat_alu;
  logic [1:0]        lat_ra;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_we;
  logic              lat_load;
  logic              lat_wb_sel;
  logic              lat_data_sel;
  logic              lat_reg_en;

  assign mem_op    = mem_wr_en_in | (wb_data_sel_in == WB_SEL_MEM);
  assign mem_state = state;

  assign dmem_req   = (state == ACCESS);
  assign dmem_we    = lat_we;
  assign dmem_addr  = lat_addr;
  assign dmem_wdata = lat_wdata;

  assign timer_en  = (state == ACCESS);
  assign timer_clr = (state != ACCESS) | dmem_ack | expired;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (expired)
  );

  // Stall upstream while a memory op is being accepted or is waiting; release
  // on the cycle it retires (ack or timeout) so upstream advances on that edge.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = mem_op;
      ACCESS:  stall = ~(dmem_ack | expired);
      default: stall = 1'b0;
    endcase
    if (!rst) stall = 1'b0;
  end

  // FSM plus MEM/WB register: every cycle that retires nothing emits a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      mem_err         <= 1'b0;
      alu_out         <= '0;
      mem_data_out    <= '0;
      ra_out          <= '0;
      wb_wb_sel_out   <= 1'b0;
      wb_data_sel_out <= 1'b0;
      wb_reg_en_out   <= 1'b0;
      lat_alu         <= '0;
      lat_ra          <= '0;
      lat_addr        <= '0;
      lat_wdata       <= '0;
      lat_we          <= 1'b0;
      lat_load        <= 1'b0;
      lat_wb_sel      <= 1'b0;
      lat_data_sel    <= 1'b0;
      lat_reg_en      <= 1'b0;
    end else begin
      alu_out         <= '0;
      mem_data_out    <= '0;
      ra_out          <= '0;
      wb_wb_sel_out   <= 1'b0;
      wb_data_sel_out <= 1'b0;
      wb_reg_en_out   <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op) begin
            lat_alu      <= alu_in;
            lat_ra       <= ra_in;
            lat_addr     <= mem_imm_sel_in ? ea_in : ADDR_W'(alu_in);
            lat_wdata    <= mem_imm_sel_in ? alu_in : DATA_W'(ea_in);
            lat_we       <= mem_wr_en_in;
            lat_load     <= (wb_data_sel_in == WB_SEL_MEM) & ~mem_wr_en_in;
            lat_wb_sel   <= wb_wb_sel_in;
            lat_data_sel <= wb_data_sel_in;
            lat_reg_en   <= wb_reg_en_in;
            state        <= ACCESS;
          end else begin
            alu_out         <= alu_in;
            ra_out          <= ra_in;
            wb_wb_sel_out   <= wb_wb_sel_in;
            wb_data_sel_out <= wb_data_sel_in;
            wb_reg_en_out   <= wb_reg_en_in;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            alu_out         <= lat_alu;
            ra_out          <= lat_ra;
            wb_wb_sel_out   <= lat_wb_sel;
            wb_data_sel_out <= lat_data_sel;
            wb_reg_en_out   <= lat_reg_en;
            mem_data_out    <= lat_load ? dmem_rdata : '0;
            state           <= IDLE;
          end else if (expired) begin
            mem_err <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pipeline_mem_stage.md
Name: pipeline_mem_stage

Overview:
- Memory stage of the 8-bit pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes its outputs: ALU result, destination register address `ra`, effective address `ea`, and the mem/wb control bits.
- Performs data-memory loads and stores over a variable-latency req/ack port, stalling upstream while an access is outstanding.
- Registers everything the write-back stage needs (the MEM/WB boundary).

Parameters:
- ADDR_W, 8, data-memory address width.
- DATA_W, 8, datapath width.
- TIMEOUT, 15, maximum ACCESS cycles without `dmem_ack` before the access is abandoned (1..255).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; asynchronous, active-low
- alu_in  in  DATA_W  ALU result from EX/MEM
- ra_in  in  2  destination register address
- ea_in  in  ADDR_W  effective address / immediate
- mem_wr_en_in  in  1  store request
- mem_imm_sel_in  in  1  address/data source select
- wb_wb_sel_in  in  1  write-back control, passed through
- wb_data_sel_in  in  1  1 = load (write-back data comes from memory)
- wb_reg_en_in  in  1  register-file write enable
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  ADDR_W  memory address
- dmem_wdata  out  DATA_W  store data
- dmem_rdata  in  DATA_W  load data, valid with `dmem_ack`
- dmem_ack  in  1  one-cycle completion pulse
- stall  out  1  upstream must hold EX/MEM contents
- alu_out  out  DATA_W  registered ALU result
- mem_data_out  out  DATA_W  registered load data
- ra_out  out  2  registered destination
- wb_wb_sel_out  out  1  registered control
- wb_data_sel_out  out  1  registered control
- wb_reg_en_out  out  1  registered control
- mem_err  out  1  sticky timeout flag

Behaviour:
- Reset: `rst` low clears all registered outputs to 0, state to IDLE, timer to 0 and `mem_err` to 0, immediately and independent of `clk`.
- Reset mid-access: `dmem_req` drops asynchronously and the access is discarded.
- Op classification:
  - mem_op = `mem_wr_en_in` | `wb_data_sel_in`.
  - If both are set, the store wins and the load data is 0.
- Address and store data:
  - `mem_imm_sel_in` = 1: address = `ea_in`, data = `alu_in`.
  - `mem_imm_sel_in` = 0: address = `alu_in`, data = `ea_in`.
- Non-mem op in IDLE:
  - 1-cycle pass-through register to the `*_out` ports.
  - `mem_data_out` = 0.
  - `stall` = 0.
- FSM states: IDLE, ACCESS.
- IDLE with mem_op:
  - `stall` = 1 combinationally.
  - Latch `ra`, `alu`, address, wdata, `we` and wb controls; go to ACCESS.
  - Outputs a bubble that cycle: all `*_out` = 0.
- ACCESS:
  - `dmem_req` = 1; `dmem_addr`, `dmem_wdata` and `dmem_we` are driven from the latches and held stable.
  - `stall` = 1 unless `dmem_ack` is high.
  - Timer increments every cycle without ack.
- `dmem_ack` in ACCESS:
  - `stall` deasserts combinationally that cycle, so upstream advances on the same edge.
  - At the edge: `*_out` loaded from the latches; `mem_data_out` = `dmem_rdata` for loads, 0 for stores.
  - Timer cleared; next state IDLE.
- Timing:
  - Non-mem op: 1 cycle.
  - Mem op: 1 + N cycles, where N ≥ 1 is the number of ACCESS cycles up to and including the ack.
  - Back-to-back mem ops: the following op enters IDLE on the next cycle, giving one bubble between them.
- Timeout: timer reaches TIMEOUT with no ack →
  - `mem_err` set (sticky until reset);
  - op retired as a bubble, `wb_reg_en_out` = 0;
  - `stall` released that cycle; back to IDLE.
  - Ack arriving on the timeout cycle takes priority: normal completion, no error.
- `dmem_ack` in IDLE is ignored.
- `dmem_req` is never asserted outside ACCESS.

Decomposition:
- Shared package `cpu_pkg` holds:
  - DATA_W and ADDR_W constants;
  - the `mem_state_t` enum {IDLE, ACCESS};
  - the wb_data_sel encoding constant for "from memory".
- One sub-module, `mem_wait_timer`: saturating counter with clear, enable and `expired` output (width $clog2(TIMEOUT+1)).

Test Plan:
- Reset: hold `rst` low mid-ACCESS → `dmem_req`, `stall` and all `*_out` go to 0 asynchronously; `mem_err` = 0.
- ALU op: `alu_in` = 0x3C, `ra_in` = 2, `wb_reg_en_in` = 1, no mem → next edge `alu_out` = 0x3C, `ra_out` = 2, `wb_reg_en_out` = 1; `stall` never high.
- Load: `mem_imm_sel_in` = 1, `ea_in` = 0x80, `wb_data_sel_in` = 1; ack after 3 cycles with `dmem_rdata` = 0xA5 →
  - `dmem_addr` = 0x80, `dmem_we` = 0;
  - `stall` high for 3 cycles;
  - `mem_data_out` = 0xA5, `wb_data_sel_out` = 1.
- Store: `mem_imm_sel_in` = 0, `alu_in` = 0x10, `ea_in` = 0x55, `mem_wr_en_in` = 1; ack in the first ACCESS cycle → `dmem_addr` = 0x10, `dmem_wdata` = 0x55, `dmem_we` = 1; `mem_data_out` = 0.
- Timeout: load with no ack →
  - `stall` high for TIMEOUT+1 cycles, then `mem_err` = 1 and a bubble (`wb_reg_en_out` = 0);
  - the next ALU op passes normally while `mem_err` stays 1.
- Boundary: ack exactly on the TIMEOUT cycle → normal completion, `mem_err` stays 0; stray ack in IDLE → no effect.
